// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage in-order pipeline without forwarding:
// destination scoreboard over EX/MEM/WB, RAW stall, branch flush and perf counters.
module hazard_ctrl #(
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_wait_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic             id_rs1_used_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_wR_i,
  input  logic             id_reg_we_i,
  input  logic             ex_taken_i,
  output logic             front_stop_o,
  output logic             id_ex_stop_o,
  output logic             id_ex_bubble_o,
  output logic             flush_o,
  output logic             raw_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } slot_t;

  typedef enum logic [1:0] {
    CTL_RUN    = 2'd0,
    CTL_FREEZE = 2'd1,
    CTL_FLUSH  = 2'd2,
    CTL_STALL  = 2'd3
  } ctl_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t            r_s_ex;
  slot_t            r_s_mem;
  slot_t            r_s_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic  w_wb_chk;
  logic  w_rs1_hit;
  logic  w_rs2_hit;
  logic  w_raw;
  ctl_e  w_ctl;
  slot_t w_ex_next;

  // With a write-before-read register file the WB slot is already visible to ID.
  assign w_wb_chk = !WB_BYPASS;

  assign w_rs1_hit = (id_rs1_i != 5'd0) &&
                     ((r_s_ex.v  && (r_s_ex.rd  == id_rs1_i)) ||
                      (r_s_mem.v && (r_s_mem.rd == id_rs1_i)) ||
                      (w_wb_chk && r_s_wb.v && (r_s_wb.rd == id_rs1_i)));

  assign w_rs2_hit = (id_rs2_i != 5'd0) &&
                     ((r_s_ex.v  && (r_s_ex.rd  == id_rs2_i)) ||
                      (r_s_mem.v && (r_s_mem.rd == id_rs2_i)) ||
                      (w_wb_chk && r_s_wb.v && (r_s_wb.rd == id_rs2_i)));

  assign w_raw = id_valid_i &&
                 ((id_rs1_used_i && w_rs1_hit) || (id_rs2_used_i && w_rs2_hit));

  assign raw_stall_o = w_raw;

  always_comb begin
    w_ctl = CTL_RUN;
    if (mem_wait_i) begin
      w_ctl = CTL_FREEZE;
    end else if (ex_taken_i) begin
      w_ctl = CTL_FLUSH;
    end else if (w_raw) begin
      w_ctl = CTL_STALL;
    end
  end

  always_comb begin
    front_stop_o   = 1'b0;
    id_ex_stop_o   = 1'b0;
    id_ex_bubble_o = 1'b0;
    flush_o        = 1'b0;
    case (w_ctl)
      CTL_FREEZE: begin
        front_stop_o = 1'b1;
        id_ex_stop_o = 1'b1;
      end
      CTL_FLUSH: begin
        flush_o        = 1'b1;
        id_ex_bubble_o = 1'b1;
      end
      CTL_STALL: begin
        front_stop_o   = 1'b1;
        id_ex_bubble_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A bubble enters EX as an empty slot; x0 destinations are never tracked.
  always_comb begin
    w_ex_next = '0;
    if (!id_ex_bubble_o) begin
      w_ex_next.v  = id_valid_i && id_reg_we_i && (id_wR_i != 5'd0);
      w_ex_next.rd = id_wR_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ex  <= '0;
      r_s_mem <= '0;
      r_s_wb  <= '0;
    end else if (!mem_wait_i) begin
      r_s_wb  <= r_s_mem;
      r_s_mem <= r_s_ex;
      r_s_ex  <= w_ex_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_ctl == CTL_STALL) && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if ((w_ctl == CTL_FLUSH) && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (bypass / no bypass / 4-bit counters)
// share stimulus; a reference model feeds a scoreboard checked every cycle.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mem_wait, ex_taken, id_valid, rs1_used, rs2_used, reg_we;
  logic [4:0] rs1, rs2, wr;

  logic [2:0]  o_front, o_idex, o_bub, o_fl, o_raw;
  logic [31:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;
  logic [31:0] o_sc [3];
  logic [31:0] o_fc [3];

  assign o_sc[0] = sc0;
  assign o_sc[1] = sc1;
  assign o_sc[2] = {28'd0, sc2};
  assign o_fc[0] = fc0;
  assign o_fc[1] = fc1;
  assign o_fc[2] = {28'd0, fc2};

  hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(32)) u_b1 (
    .clk(clk), .rst_n(rst_n), .mem_wait_i(mem_wait), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs1_used_i(rs1_used), .id_rs2_i(rs2), .id_rs2_used_i(rs2_used),
    .id_wR_i(wr), .id_reg_we_i(reg_we), .ex_taken_i(ex_taken),
    .front_stop_o(o_front[0]), .id_ex_stop_o(o_idex[0]), .id_ex_bubble_o(o_bub[0]),
    .flush_o(o_fl[0]), .raw_stall_o(o_raw[0]), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(32)) u_b0 (
    .clk(clk), .rst_n(rst_n), .mem_wait_i(mem_wait), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs1_used_i(rs1_used), .id_rs2_i(rs2), .id_rs2_used_i(rs2_used),
    .id_wR_i(wr), .id_reg_we_i(reg_we), .ex_taken_i(ex_taken),
    .front_stop_o(o_front[1]), .id_ex_stop_o(o_idex[1]), .id_ex_bubble_o(o_bub[1]),
    .flush_o(o_fl[1]), .raw_stall_o(o_raw[1]), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .mem_wait_i(mem_wait), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs1_used_i(rs1_used), .id_rs2_i(rs2), .id_rs2_used_i(rs2_used),
    .id_wR_i(wr), .id_reg_we_i(reg_we), .ex_taken_i(ex_taken),
    .front_stop_o(o_front[2]), .id_ex_stop_o(o_idex[2]), .id_ex_bubble_o(o_bub[2]),
    .flush_o(o_fl[2]), .raw_stall_o(o_raw[2]), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
  );

  typedef struct packed {
    logic [2:0] front, idex, bub, fl, raw;
    logic [2:0][31:0] sc, fc;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  string tname = "init";

  logic [2:0] last_front, last_idex, last_bub, last_fl;

  // Reference model state, one copy per instance: slot 0 = EX, 1 = MEM, 2 = WB.
  bit         m_v  [3][3];
  logic [4:0] m_rd [3][3];
  longint     m_sc [3];
  longint     m_fc [3];

  function automatic bit byp(input int d);
    return d != 1;
  endfunction

  function automatic longint cmax(input int d);
    return (d == 2) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic bit m_hit(input int d, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2 && byp(d)) continue;
      if (m_v[d][k] && m_rd[d][k] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 3; k++) begin
        m_v[d][k]  = 1'b0;
        m_rd[d][k] = 5'd0;
      end
      m_sc[d] = 0;
      m_fc[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({o_front[d], o_idex[d], o_bub[d], o_fl[d], o_raw[d]} !==
            {mon_e.front[d], mon_e.idex[d], mon_e.bub[d], mon_e.fl[d], mon_e.raw[d]}) begin
          errors++;
          $display("FAIL %s dut%0d ctl{front,idex,bub,flush,raw} got %b%b%b%b%b want %b%b%b%b%b",
                   tname, d, o_front[d], o_idex[d], o_bub[d], o_fl[d], o_raw[d],
                   mon_e.front[d], mon_e.idex[d], mon_e.bub[d], mon_e.fl[d], mon_e.raw[d]);
        end
        checks++;
        if (o_sc[d] !== mon_e.sc[d]) begin
          errors++;
          $display("FAIL %s dut%0d stall_cnt got %0d want %0d", tname, d, o_sc[d], mon_e.sc[d]);
        end
        checks++;
        if (o_fc[d] !== mon_e.fc[d]) begin
          errors++;
          $display("FAIL %s dut%0d flush_cnt got %0d want %0d", tname, d, o_fc[d], mon_e.fc[d]);
        end
      end
    end
  end

  // Entered and left at posedge+1: drive one ID/EX transaction, queue expectations, advance model.
  task automatic step(input logic mw, input logic tk, input logic iv,
                      input logic [4:0] a1, input logic ua1,
                      input logic [4:0] a2, input logic ua2,
                      input logic [4:0] w, input logic we_in);
    exp_t e;
    mem_wait = mw; ex_taken = tk; id_valid = iv;
    rs1 = a1; rs1_used = ua1; rs2 = a2; rs2_used = ua2; wr = w; reg_we = we_in;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      e.raw[d] = iv && ((ua1 && m_hit(d, a1)) || (ua2 && m_hit(d, a2)));
      if (mw) begin
        e.front[d] = 1'b1; e.idex[d] = 1'b1;
      end else if (tk) begin
        e.fl[d] = 1'b1; e.bub[d] = 1'b1;
      end else if (e.raw[d]) begin
        e.front[d] = 1'b1; e.bub[d] = 1'b1;
      end
      e.sc[d] = m_sc[d][31:0];
      e.fc[d] = m_fc[d][31:0];
    end
    q.push_back(e);
    @(negedge clk);
    #1;
    last_front = o_front; last_idex = o_idex; last_bub = o_bub; last_fl = o_fl;
    $display("txn %-10s mw=%b tk=%b iv=%b rs1=%0d/%b rs2=%0d/%b wr=%0d/%b front=%b bub=%b flush=%b",
             tname, mw, tk, iv, a1, ua1, a2, ua2, w, we_in, o_front, o_bub, o_fl);
    if (!mw) begin
      for (int d = 0; d < 3; d++) begin
        m_v[d][2] = m_v[d][1]; m_rd[d][2] = m_rd[d][1];
        m_v[d][1] = m_v[d][0]; m_rd[d][1] = m_rd[d][0];
        m_v[d][0]  = e.bub[d] ? 1'b0 : (iv && we_in && (w != 5'd0));
        m_rd[d][0] = e.bub[d] ? 5'd0 : w;
        if (tk && m_fc[d] < cmax(d)) m_fc[d]++;
        if (!tk && e.raw[d] && m_sc[d] < cmax(d)) m_sc[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic prod(input logic [4:0] r);
    step(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, r, 1'b1);
  endtask

  task automatic cons(input logic [4:0] r, input logic mw, input logic tk);
    step(mw, tk, 1'b1, r, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_wait = 0; ex_taken = 0; id_valid = 0; rs1_used = 0; rs2_used = 0; reg_we = 0;
    rs1 = 0; rs2 = 0; wr = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tname = "reset";
    do_reset();
    idle();
    idle();
    checks++;
    if ({o_front, o_idex, o_bub, o_fl, o_raw} !== 15'd0) begin
      errors++;
      $display("FAIL reset outputs got %b want 0", {o_front, o_idex, o_bub, o_fl, o_raw});
    end
    checks++;
    if (o_sc[0] !== 32'd0 || o_fc[0] !== 32'd0 || o_sc[2] !== 32'd0) begin
      errors++;
      $display("FAIL reset counters got sc=%0d fc=%0d sc4=%0d want 0", o_sc[0], o_fc[0], o_sc[2]);
    end
  endtask

  task automatic test_raw_stall();
    int n0, n1, nz;
    tname = "raw_stall";
    n0 = 0; n1 = 0;
    prod(5'd5);
    repeat (4) begin
      cons(5'd5, 1'b0, 1'b0);
      n0 += int'(last_front[0]);
      n1 += int'(last_front[1]);
    end
    idle();
    checks++;
    if (n0 !== 2) begin errors++; $display("FAIL raw_stall bypass_cycles got %0d want 2", n0); end
    checks++;
    if (n1 !== 3) begin errors++; $display("FAIL raw_stall nobypass_cycles got %0d want 3", n1); end
    checks++;
    if (o_sc[0] !== 32'd2) begin errors++; $display("FAIL raw_stall bypass_cnt got %0d want 2", o_sc[0]); end
    checks++;
    if (o_sc[1] !== 32'd3) begin errors++; $display("FAIL raw_stall nobypass_cnt got %0d want 3", o_sc[1]); end
    tname = "x0_dest";
    nz = 0;
    prod(5'd0);
    repeat (2) begin
      cons(5'd0, 1'b0, 1'b0);
      nz += int'(last_front[0]) + int'(last_front[1]) + int'(last_front[2]);
    end
    checks++;
    if (nz !== 0) begin errors++; $display("FAIL x0_dest stall_cycles got %0d want 0", nz); end
    tname = "rs2_path";
    prod(5'd7);
    step(1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
    checks++;
    if (last_front[0] !== 1'b1) begin errors++; $display("FAIL rs2_path front got %b want 1", last_front[0]); end
    repeat (3) idle();
  endtask

  task automatic test_flush();
    logic [31:0] f_before;
    tname = "flush";
    f_before = o_fc[0];
    prod(5'd9);
    cons(5'd9, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1);
    checks++;
    if ({last_front[0], last_bub[0], last_fl[0]} !== 3'b011) begin
      errors++;
      $display("FAIL flush {front,bub,flush} got %b want 011", {last_front[0], last_bub[0], last_fl[0]});
    end
    cons(5'd12, 1'b0, 1'b0);
    checks++;
    if (last_front[0] !== 1'b0) begin errors++; $display("FAIL flush killed_dest_stall got %b want 0", last_front[0]); end
    idle();
    checks++;
    if (o_fc[0] !== f_before + 32'd1) begin
      errors++; $display("FAIL flush count got %0d want %0d", o_fc[0], f_before + 32'd1);
    end
    tname = "b2b_taken";
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    idle();
    checks++;
    if (o_fc[0] !== f_before + 32'd3) begin
      errors++; $display("FAIL b2b_taken count got %0d want %0d", o_fc[0], f_before + 32'd3);
    end
    repeat (3) idle();
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0, s1;
    int n0, n1;
    tname = "mem_wait";
    prod(5'd5);
    cons(5'd5, 1'b0, 1'b0);
    s0 = o_sc[0]; s1 = o_sc[1];
    repeat (4) begin
      cons(5'd5, 1'b1, 1'b1);
      checks++;
      if ({last_front[0], last_idex[0], last_bub[0], last_fl[0]} !== 4'b1100) begin
        errors++;
        $display("FAIL mem_wait {front,idex,bub,flush} got %b want 1100",
                 {last_front[0], last_idex[0], last_bub[0], last_fl[0]});
      end
    end
    checks++;
    if (o_sc[0] !== s0 || o_sc[1] !== s1) begin
      errors++; $display("FAIL mem_wait held_cnt got %0d/%0d want %0d/%0d", o_sc[0], o_sc[1], s0, s1);
    end
    n0 = 0; n1 = 0;
    repeat (3) begin
      cons(5'd5, 1'b0, 1'b0);
      n0 += int'(last_front[0]);
      n1 += int'(last_front[1]);
    end
    checks++;
    if (n0 !== 1 || n1 !== 2) begin
      errors++; $display("FAIL mem_wait remaining got %0d/%0d want 1/2", n0, n1);
    end
    repeat (3) idle();
  endtask

  task automatic test_saturate();
    tname = "saturate";
    do_reset();
    repeat (8) begin
      prod(5'd5);
      repeat (3) cons(5'd5, 1'b0, 1'b0);
    end
    checks++;
    if (o_sc[2] !== 32'd15) begin errors++; $display("FAIL saturate cnt4 got %0d want 15", o_sc[2]); end
    checks++;
    if (o_sc[0] !== 32'd16) begin errors++; $display("FAIL saturate cnt32 got %0d want 16", o_sc[0]); end
    tname = "reset_mid";
    prod(5'd5);
    id_valid = 1'b1; rs1 = 5'd5; rs1_used = 1'b1; rs2_used = 1'b0; reg_we = 1'b0; wr = 5'd0;
    #1;
    checks++;
    if (o_raw[0] !== 1'b1 || o_front[0] !== 1'b1) begin
      errors++; $display("FAIL reset_mid pre_stall got raw=%b front=%b want 1/1", o_raw[0], o_front[0]);
    end
    rst_n = 1'b0;
    #1;
    $display("txn %-10s async reset asserted front=%b bub=%b raw=%b", tname, o_front, o_bub, o_raw);
    checks++;
    if ({o_front, o_bub, o_raw, o_idex, o_fl} !== 15'd0) begin
      errors++; $display("FAIL reset_mid outputs got %b want 0", {o_front, o_bub, o_raw, o_idex, o_fl});
    end
    checks++;
    if (o_sc[0] !== 32'd0 || o_sc[2] !== 32'd0) begin
      errors++; $display("FAIL reset_mid counters got %0d/%0d want 0/0", o_sc[0], o_sc[2]);
    end
    do_reset();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_wait = 0; ex_taken = 0; id_valid = 0; rs1_used = 0; rs2_used = 0; reg_we = 0;
    rs1 = 0; rs2 = 0; wr = 0;
    model_clear();
    test_reset();
    test_raw_stall();
    test_flush();
    test_mem_wait();
    test_saturate();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard controller for the 5-stage pipeline. It generates the stop, bubble and flush signals consumed by the PC, IF/ID and ID/EX pipeline registers.
- The pipeline has no forwarding network. This block keeps a 3-slot destination scoreboard covering the EX, MEM and WB stages, and stalls the front end while ID reads a register still in flight.
- It also flushes the younger instructions when EX resolves a taken branch or jump, and keeps saturating performance counters for stalls and flushes.

Parameters:
- WB_BYPASS, 1: 1 = register file is write-before-read, so the WB slot never causes a hazard. 0 = the WB slot is checked like the others.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_wait_i  in  1  global freeze (memory not ready); the whole pipeline holds
- id_valid_i  in  1  ID holds a real, non-discarded instruction
- id_rs1_i  in  5  ID source register 1
- id_rs1_used_i  in  1  ID reads rs1
- id_rs2_i  in  5  ID source register 2
- id_rs2_used_i  in  1  ID reads rs2
- id_wR_i  in  5  ID destination register
- id_reg_we_i  in  1  ID writes the register file
- ex_taken_i  in  1  instruction in EX redirects the PC (taken branch or jump)
- front_stop_o  out  1  hold PC and IF/ID
- id_ex_stop_o  out  1  hold ID/EX (pipeline_stop_i of ID/EX)
- id_ex_bubble_o  out  1  load a NOP into ID/EX this edge
- flush_o  out  1  discard IF and ID contents; IF/ID loads discard-marked entries
- raw_stall_o  out  1  raw data-hazard indication, for debug
- stall_cnt_o  out  CNT_W  count of data-hazard stall cycles
- flush_cnt_o  out  CNT_W  count of flush events

Behaviour:
- Scoreboard slots S_EX, S_MEM, S_WB. Each slot is {v, rd[4:0]}.
- Reset: all slots, both counters and every registered value go to 0. The outputs are combinational from the slots and inputs, so with mem_wait_i = 0 and ex_taken_i = 0 all outputs are 0 after reset.
- hit(r) = r != 0 and one of the following holds for r:
  - S_EX.v and S_EX.rd == r
  - S_MEM.v and S_MEM.rd == r
  - (!WB_BYPASS) and S_WB.v and S_WB.rd == r
- raw = id_valid_i and ((id_rs1_used_i and hit(id_rs1_i)) or (id_rs2_used_i and hit(id_rs2_i))).
- raw_stall_o = raw, unqualified.
- Output priority, highest first:
  1. mem_wait_i = 1: front_stop_o = 1, id_ex_stop_o = 1, bubble = 0, flush = 0. Slots and counters hold. A pending ex_taken_i is not lost, because EX is held and re-presents it.
  2. ex_taken_i = 1: flush_o = 1, id_ex_bubble_o = 1 (kills ID), front_stop_o = 0, id_ex_stop_o = 0. raw is ignored.
  3. raw = 1: front_stop_o = 1, id_ex_bubble_o = 1, id_ex_stop_o = 0.
  4. Otherwise all stop/bubble/flush outputs are 0.
- Slot update on each clk edge, when mem_wait_i = 0:
  - S_WB <= S_MEM
  - S_MEM <= S_EX
  - S_EX <= {0, 0} if id_ex_bubble_o, else {id_valid_i & id_reg_we_i & (id_wR_i != 0), id_wR_i}
- Resulting stall latency for a dependent instruction directly behind its producer, no freeze:
  - WB_BYPASS = 1: 2 stall cycles.
  - WB_BYPASS = 0: 3 stall cycles.
- Counters (when mem_wait_i = 0):
  - stall_cnt_o increments on every cycle with case 3 active.
  - flush_cnt_o increments on every cycle with case 2 active.
  - Both saturate at all-ones; there is no wrap-around.
- rd = x0 never hazards: it is never marked valid and is never matched.
- Back-to-back taken branches: each cycle with ex_taken_i = 1 flushes independently.
- Reset asserted mid-stall: slots clear immediately (asynchronously), and the stall drops in the same cycle.

Test Plan:
- Reset, then idle with id_valid_i = 0 -> all outputs 0, both counters 0.
- WB_BYPASS = 1: ADD x5 (we = 1), next cycle ID reads rs1 = 5 -> front_stop_o = 1 and bubble = 1 for exactly 2 cycles, then 0; stall_cnt_o = 2.
- Same sequence with WB_BYPASS = 0 -> 3 stall cycles; stall_cnt_o = 3. Producer with wR = 0 -> no stall.
- Stall in progress plus ex_taken_i = 1 -> flush_o = 1, bubble = 1, front_stop_o = 0 that cycle; flush_cnt_o = 1; S_EX receives an invalid entry.
- mem_wait_i held 4 cycles during a pending hazard -> both stops = 1 and counters unchanged for those 4 cycles; the stall completes with its original remaining cycle count afterwards.
- Preload stall_cnt_o = all-ones via forced stalls (CNT_W = 4: 15 stalls) -> the 16th stall cycle leaves the counter at 15; then assert rst_n = 0 mid-stall -> outputs 0 immediately.
